// File: rtl/data_store_unit_pkg.sv
// data_store_unit_pkg: shared datapath widths and the clog2 helper for the BIP store path
package data_store_unit_pkg;
  localparam int E_BITS_DEF = 16;
  localparam int ADDR_BITS_DEF = 11;
  localparam int SB_DEPTH_DEF = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/data_store_unit_if.sv
// data_store_unit_if: store handshake, operand load port and data RAM port
interface data_store_unit_if import data_store_unit_pkg::*; #(
  parameter int E_BITS = E_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int SB_DEPTH = SB_DEPTH_DEF
);
  logic                   i_st_valid;
  logic                   o_st_ready;
  logic [ADDR_BITS-1:0]   i_st_addr;
  logic [E_BITS-1:0]      i_st_data;
  logic                   i_ld_req;
  logic [ADDR_BITS-1:0]   i_ld_addr;
  logic                   o_ld_valid;
  logic [E_BITS-1:0]      o_ld_data;
  logic                   o_ram_we;
  logic                   o_ram_re;
  logic [ADDR_BITS-1:0]   o_ram_addr;
  logic [E_BITS-1:0]      o_ram_wdata;
  logic [E_BITS-1:0]      i_ram_rdata;
  logic [clog2(SB_DEPTH):0] o_sb_count;
  modport master (
    output i_st_valid, i_st_addr, i_st_data, i_ld_req, i_ld_addr, i_ram_rdata,
    input  o_st_ready, o_ld_valid, o_ld_data, o_ram_we, o_ram_re, o_ram_addr, o_ram_wdata, o_sb_count
  );
  modport slave (
    input  i_st_valid, i_st_addr, i_st_data, i_ld_req, i_ld_addr, i_ram_rdata,
    output o_st_ready, o_ld_valid, o_ld_data, o_ram_we, o_ram_re, o_ram_addr, o_ram_wdata, o_sb_count
  );
endinterface

// File: rtl/data_store_unit_store_buffer_fifo.sv
// store_buffer_fifo: circular store buffer with a youngest-match lookup for load forwarding
module store_buffer_fifo import data_store_unit_pkg::*; #(
  parameter int E_BITS = E_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DEPTH = SB_DEPTH_DEF,
  localparam int PW = clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_push,
  input  logic [ADDR_BITS-1:0] i_push_addr,
  input  logic [E_BITS-1:0]    i_push_data,
  input  logic                 i_pop,
  input  logic [ADDR_BITS-1:0] i_lk_addr,
  output logic                 o_lk_hit,
  output logic [E_BITS-1:0]    o_lk_data,
  output logic [ADDR_BITS-1:0] o_head_addr,
  output logic [E_BITS-1:0]    o_head_data,
  output logic [CW-1:0]        o_count
);
  logic [ADDR_BITS-1:0] r_addr [DEPTH];
  logic [E_BITS-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0]     r_valid;
  logic [PW-1:0]        r_head, r_tail;
  logic [CW-1:0]        r_count;

  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_valid <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_valid[r_tail] <= 1'b1;
      if (i_pop) r_valid[r_head] <= 1'b0;
      r_tail <= r_tail + PW'(i_push);
      r_head <= r_head + PW'(i_pop);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end

  always_ff @(posedge i_clock)
    if (i_push) begin
      r_addr[r_tail] <= i_push_addr;
      r_data[r_tail] <= i_push_data;
    end

  // Scan from oldest to youngest so the last match wins
  always_comb begin
    o_lk_hit = 1'b0;
    o_lk_data = '0;
    for (int k = 0; k < DEPTH; k++)
      if (r_valid[r_head + PW'(k)] && r_addr[r_head + PW'(k)] == i_lk_addr) begin
        o_lk_hit = 1'b1;
        o_lk_data = r_data[r_head + PW'(k)];
      end
  end

  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];
  assign o_count = r_count;
endmodule

// File: rtl/data_store_unit.sv
// data_store_unit: buffers STO writes into data RAM and forwards pending stores to operand loads
module data_store_unit import data_store_unit_pkg::*; #(
  parameter int E_BITS = E_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int SB_DEPTH = SB_DEPTH_DEF
) (
  input logic              i_clock,
  input logic              i_reset,
  data_store_unit_if.slave bus
);
  localparam int CW = clog2(SB_DEPTH) + 1;
  logic                 w_hit, w_miss, w_drain, w_push;
  logic [E_BITS-1:0]    w_hit_data, w_head_data;
  logic [ADDR_BITS-1:0] w_head_addr;
  logic [CW-1:0]        w_count;
  logic                 r_ld_valid, r_ld_hit;
  logic [E_BITS-1:0]    r_hit_data;

  store_buffer_fifo #(.E_BITS(E_BITS), .ADDR_BITS(ADDR_BITS), .DEPTH(SB_DEPTH)) u_sb (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_push     (w_push),
    .i_push_addr(bus.i_st_addr),
    .i_push_data(bus.i_st_data),
    .i_pop      (w_drain),
    .i_lk_addr  (bus.i_ld_addr),
    .o_lk_hit   (w_hit),
    .o_lk_data  (w_hit_data),
    .o_head_addr(w_head_addr),
    .o_head_data(w_head_data),
    .o_count    (w_count)
  );

  assign bus.o_st_ready = w_count < CW'(SB_DEPTH);
  assign w_push = bus.i_st_valid && bus.o_st_ready;
  // A missing load owns the RAM port; no read is issued while reset is held
  assign w_miss = bus.i_ld_req && !w_hit && !i_reset;
  assign w_drain = !w_miss && w_count != '0;
  assign bus.o_ram_re = w_miss;
  assign bus.o_ram_we = w_drain;
  assign bus.o_ram_addr = w_miss ? bus.i_ld_addr : w_head_addr;
  assign bus.o_ram_wdata = w_head_data;
  assign bus.o_sb_count = w_count;
  assign bus.o_ld_valid = r_ld_valid;
  assign bus.o_ld_data = !r_ld_valid ? '0 : r_ld_hit ? r_hit_data : bus.i_ram_rdata;

  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_ld_valid <= 1'b0;
      r_ld_hit <= 1'b0;
      r_hit_data <= '0;
    end else begin
      r_ld_valid <= bus.i_ld_req;
      r_ld_hit <= w_hit;
      r_hit_data <= w_hit_data;
    end
endmodule

// File: tb/tb_data_store_unit.sv
// tb_data_store_unit: directed stimulus; a memory-semantics model is compared every cycle
module tb_data_store_unit;
  typedef struct { logic [10:0] a; logic [15:0] d; } st_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st_valid = 1'b0, ld_req = 1'b0;
  logic [10:0] st_addr = '0, ld_addr = '0;
  logic [15:0] st_data = '0;
  int errors = 0, checks = 0;
  st_t q[$];
  logic [15:0] mm [2048];
  logic [15:0] ram [2048];
  logic p_ld = 1'b0;
  logic [15:0] p_data = '0;

  data_store_unit_if #(.E_BITS(16), .ADDR_BITS(11), .SB_DEPTH(2)) bus();
  data_store_unit #(.E_BITS(16), .ADDR_BITS(11), .SB_DEPTH(2)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  assign bus.i_st_valid = st_valid;
  assign bus.i_st_addr = st_addr;
  assign bus.i_st_data = st_data;
  assign bus.i_ld_req = ld_req;
  assign bus.i_ld_addr = ld_addr;

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Value a load must observe: youngest pending store, else committed memory
  function automatic logic [16:0] lookup(input logic [10:0] a);
    logic [16:0] r;
    r = {1'b0, mm[a]};
    foreach (q[i]) if (q[i].a == a) r = {1'b1, q[i].d};
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = '0;
    ram[16] = 16'h1234;
    bus.i_ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.o_ram_we) ram[bus.o_ram_addr] = bus.o_ram_wdata;
      if (bus.o_ram_re) bus.i_ram_rdata = ram[bus.o_ram_addr];
    end
  end

  initial begin
    for (int i = 0; i < 2048; i++) mm[i] = '0;
    mm[16] = 16'h1234;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        p_ld = 1'b0;
        p_data = '0;
      end else begin
        logic [16:0] r;
        bit drain, push;
        r = lookup(ld_addr);
        drain = !(ld_req && !r[16]) && q.size() > 0;
        push = st_valid && q.size() < 2;
        p_ld = ld_req;
        p_data = r[15:0];
        if (drain) begin
          mm[q[0].a] = q[0].d;
          void'(q.pop_front());
        end
        if (push) q.push_back('{a: st_addr, d: st_data});
      end
    end
  end

  initial forever begin
    logic [16:0] r;
    bit e_re, e_we;
    @(negedge clk);
    #3;
    if (rst) begin
      chk("rst_ready", 32'(bus.o_st_ready), 1);
      chk("rst_count", 32'(bus.o_sb_count), 0);
      chk("rst_we", 32'(bus.o_ram_we), 0);
      chk("rst_re", 32'(bus.o_ram_re), 0);
      chk("rst_ld_valid", 32'(bus.o_ld_valid), 0);
      chk("rst_ld_data", 32'(bus.o_ld_data), 0);
    end else begin
      r = lookup(ld_addr);
      e_re = ld_req && !r[16];
      e_we = !e_re && q.size() > 0;
      chk("m_ready", 32'(bus.o_st_ready), 32'(q.size() < 2));
      chk("m_count", 32'(bus.o_sb_count), 32'(q.size()));
      chk("m_re", 32'(bus.o_ram_re), 32'(e_re));
      chk("m_we", 32'(bus.o_ram_we), 32'(e_we));
      if (e_re) chk("m_raddr", 32'(bus.o_ram_addr), 32'(ld_addr));
      if (e_we) begin
        chk("m_waddr", 32'(bus.o_ram_addr), 32'(q[0].a));
        chk("m_wdata", 32'(bus.o_ram_wdata), 32'(q[0].d));
      end
      chk("m_ld_valid", 32'(bus.o_ld_valid), 32'(p_ld));
      if (p_ld) chk("m_ld_data", 32'(bus.o_ld_data), 32'(p_data));
    end
  end

  task automatic drive(input logic sv, input logic [10:0] sa, input logic [15:0] sd,
                       input logic lr, input logic [10:0] la);
    @(negedge clk);
    st_valid = sv;
    st_addr = sa;
    st_data = sd;
    ld_req = lr;
    ld_addr = la;
    #2;
  endtask

  initial begin
    drive(0, 0, 0, 1, 11'h010);
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("rel_count", 32'(bus.o_sb_count), 0);
    chk("rel_ready", 32'(bus.o_st_ready), 1);
    // single store drains on the next cycle
    drive(1, 11'h005, 16'h0007, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("st_we", 32'(bus.o_ram_we), 1);
    chk("st_addr", 32'(bus.o_ram_addr), 'h005);
    chk("st_wdata", 32'(bus.o_ram_wdata), 'h0007);
    drive(0, 0, 0, 0, 0);
    chk("st_count0", 32'(bus.o_sb_count), 0);
    // two stores to one address, misses hold them, then a forwarded load
    drive(1, 11'h005, 16'h0007, 1, 11'h100);
    drive(1, 11'h005, 16'h0002, 1, 11'h101);
    chk("fw_blocked", 32'(bus.o_ram_we), 0);
    drive(0, 0, 0, 1, 11'h005);
    chk("fw_no_re", 32'(bus.o_ram_re), 0);
    chk("fw_count", 32'(bus.o_sb_count), 2);
    drive(0, 0, 0, 0, 0);
    chk("fw_valid", 32'(bus.o_ld_valid), 1);
    chk("fw_data", 32'(bus.o_ld_data), 'h0002);
    drive(0, 0, 0, 0, 0);
    // load miss
    drive(0, 0, 0, 1, 11'h010);
    chk("miss_re", 32'(bus.o_ram_re), 1);
    chk("miss_addr", 32'(bus.o_ram_addr), 'h010);
    drive(0, 0, 0, 0, 0);
    chk("miss_valid", 32'(bus.o_ld_valid), 1);
    chk("miss_data", 32'(bus.o_ld_data), 'h1234);
    // full buffer under a miss stream, rejected stores, then FIFO drain
    drive(1, 11'h030, 16'hAAAA, 1, 11'h040);
    drive(1, 11'h031, 16'hBBBB, 1, 11'h041);
    for (int i = 0; i < 3; i++) begin
      drive(1, 11'h050, 16'h5555, 1, 11'h042);
      chk("full_ready", 32'(bus.o_st_ready), 0);
      chk("full_we", 32'(bus.o_ram_we), 0);
    end
    drive(0, 0, 0, 0, 0);
    chk("d1_addr", 32'(bus.o_ram_addr), 'h030);
    chk("d1_data", 32'(bus.o_ram_wdata), 'hAAAA);
    drive(0, 0, 0, 0, 0);
    chk("d2_addr", 32'(bus.o_ram_addr), 'h031);
    chk("d2_data", 32'(bus.o_ram_wdata), 'hBBBB);
    chk("d2_ready", 32'(bus.o_st_ready), 1);
    drive(0, 0, 0, 0, 0);
    // same-cycle store and load
    drive(1, 11'h020, 16'h7777, 1, 11'h020);
    chk("sc_re", 32'(bus.o_ram_re), 1);
    drive(0, 0, 0, 1, 11'h020);
    chk("sc_old", 32'(bus.o_ld_data), 'h0000);
    drive(0, 0, 0, 0, 0);
    chk("sc_new", 32'(bus.o_ld_data), 'h7777);
    // reset during a drain aborts the write
    drive(1, 11'h060, 16'h6666, 1, 11'h061);
    drive(0, 0, 0, 0, 0);
    chk("ab_we", 32'(bus.o_ram_we), 1);
    rst = 1'b1;
    #1;
    chk("ab_we_rst", 32'(bus.o_ram_we), 0);
    drive(0, 0, 0, 1, 11'h061);
    chk("ab_re_rst", 32'(bus.o_ram_re), 0);
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("ab_count", 32'(bus.o_sb_count), 0);
    drive(0, 0, 0, 1, 11'h060);
    drive(0, 0, 0, 0, 0);
    chk("ab_ram", 32'(bus.o_ld_data), 'h0000);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
